// File: rtl/baud_ctrl_if.sv
// Configuration handshake between a divisor source and the baud tick generator.
interface baud_ctrl_if #(
    parameter int unsigned DVSR_W = 11
);
    logic [DVSR_W-1:0] cfg_dvsr;
    logic              cfg_valid;
    logic              cfg_ready;

    modport master (output cfg_dvsr, output cfg_valid, input cfg_ready);
    modport slave  (input cfg_dvsr, input cfg_valid, output cfg_ready);
endinterface

// File: rtl/baud_ctrl.sv
// Baud-rate tick generator: sample tick every dvsr+1 cycles, bit tick every OVS sample ticks.
// A new divisor is deferred until both transmitter and receiver are between frames.
module baud_ctrl #(
    parameter int unsigned DVSR_W       = 11,
    parameter int unsigned DEFAULT_DVSR = 650,
    parameter int unsigned OVS          = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              en,
    baud_ctrl_if.slave        cfg,
    input  logic              tx_busy,
    input  logic              rx_busy,
    output logic              s_tick,
    output logic              bit_tick,
    output logic [DVSR_W-1:0] dvsr_active,
    output logic              cfg_applied
);

    localparam int unsigned       OVS_W    = $clog2(OVS);
    localparam logic [DVSR_W-1:0] RST_DVSR = DVSR_W'(DEFAULT_DVSR);
    localparam logic [OVS_W-1:0]  OVS_LAST = OVS_W'(OVS - 1);

    typedef enum logic [1:0] {IDLE, RUN, PEND, LOAD} state_e;

    state_e            state_q, state_d;
    logic [DVSR_W-1:0] cnt_q, cnt_d;
    logic [DVSR_W-1:0] dvsr_q, dvsr_d;
    logic [DVSR_W-1:0] pend_q, pend_d;
    logic [OVS_W-1:0]  ovs_q, ovs_d;
    logic              counting;
    logic              cnt_wrap;
    logic              accept;

    assign counting      = (state_q == RUN) || (state_q == PEND);
    assign cnt_wrap      = (cnt_q == dvsr_q);
    assign s_tick        = counting && cnt_wrap;
    assign bit_tick      = s_tick && (ovs_q == OVS_LAST);
    assign cfg.cfg_ready = (state_q == IDLE) || (state_q == RUN);
    assign accept        = cfg.cfg_valid && cfg.cfg_ready;
    assign cfg_applied   = (state_q == LOAD);
    assign dvsr_active   = dvsr_q;

    always_comb begin
        // NOTE: every output of this block gets a default first so no path can infer a latch.
        state_d = state_q;
        pend_d  = pend_q;
        dvsr_d  = dvsr_q;
        cnt_d   = '0;
        ovs_d   = '0;

        unique case (state_q)
            IDLE: begin
                if (accept)  state_d = LOAD;
                else if (en) state_d = RUN;
            end
            RUN: begin
                if (!en)         state_d = IDLE;
                else if (accept) state_d = PEND;
            end
            PEND: begin
                // Disabling the generator makes waiting for idle transceivers pointless.
                if (!en || (!tx_busy && !rx_busy)) state_d = LOAD;
            end
            LOAD: begin
                dvsr_d  = pend_q;
                state_d = en ? RUN : IDLE;
            end
            default: state_d = IDLE;
        endcase

        // An accept that coincides with RUN being disabled is dropped.
        if (accept && (state_d != IDLE)) begin
            pend_d = (cfg.cfg_dvsr == '0) ? DVSR_W'(1) : cfg.cfg_dvsr;
        end

        // Counters only advance while staying in a counting state; any other path restarts them at 0.
        if (counting && ((state_d == RUN) || (state_d == PEND))) begin
            cnt_d = cnt_wrap ? '0 : cnt_q + 1'b1;
            ovs_d = ovs_q;
            if (s_tick) ovs_d = (ovs_q == OVS_LAST) ? '0 : ovs_q + 1'b1;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            ovs_q   <= '0;
            dvsr_q  <= RST_DVSR;
            pend_q  <= RST_DVSR;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            ovs_q   <= ovs_d;
            dvsr_q  <= dvsr_d;
            pend_q  <= pend_d;
        end
    end

endmodule
